data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port 64-word data memory between the multicycle CPU MEM step (port C)
//  and a DMA/debug loader (port D). Latches one request, drives mr/mqb/mwmem for exactly
//  one access cycle, captures mdo, then returns a one-cycle ack with read data.
//  Sits between the CPU control unit / DMA engine and the data memory.
// PARAMETERS
//  DW        32  data width (mqb, mdo, wdata, rdata)
//  AW        32  address width (byte address; memory decodes mr[7:2])
//  MAX_WAIT  4   consecutive C grants while d_req is held before D is forced next (1..15)
// PORTS
//  clock    in   1   system clock; all state updates on posedge
//  reset    in   1   synchronous, active-high
//  c_req    in   1   CPU request; held with c_we/c_addr/c_wdata stable until c_ack
//  c_we     in   1   1 = write, 0 = read
//  c_addr   in   AW  CPU byte address
//  c_wdata  in   DW  CPU write data
//  c_ack    out  1   one-cycle completion pulse to CPU
//  c_rdata  out  DW  read data; valid while c_ack = 1
//  d_req    in   1   DMA request (same rules as c_req)
//  d_we     in   1   DMA write enable
//  d_addr   in   AW  DMA byte address
//  d_wdata  in   DW  DMA write data
//  d_ack    out  1   one-cycle completion pulse to DMA
//  d_rdata  out  DW  read data; valid while d_ack = 1
//  mr       out  AW  memory address
//  mqb      out  DW  memory write data
//  mwmem    out  1   memory write enable (memory writes on negedge)
//  mdo      in   DW  memory combinational read data
//  busy     out  1   1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; c_ack=d_ack=0; c_rdata=d_rdata=0; mr=mqb=0; mwmem=0; busy=0;
//    wait_cnt=0; last_grant=D (so first tie under round-robin goes to C).
//  - FSM IDLE -> ACC -> RESP -> IDLE, one cycle per state; no other transitions.
//  - IDLE: if any req, pick winner, latch we/addr/wdata and winner id -> ACC; else stay.
//  - ACC: mr=latched addr, mqb=latched wdata, mwmem=latched we; mdo captured into the
//    winner's rdata register at end of cycle (writes also capture mdo; value unspecified).
//  - RESP: winner's ack=1 for exactly one cycle; loser's ack=0; -> IDLE.
//  - Outside ACC: mr=0, mqb=0, mwmem=0 (mwmem must never be high outside ACC).
//  - Latency: req high at posedge k (in IDLE) -> ack high during cycle k+2..k+3; 3 cycles/access.
//  - Requester drops req at the posedge ending its ack cycle; a req still high in IDLE is new.
//  - Reqs are ignored in ACC and RESP; a loser keeps req high and is served next IDLE.
//  - Starvation guard: wait_cnt increments on each C grant while d_req=1, clears on any D
//    grant or when d_req=0; when wait_cnt==MAX_WAIT and both request, D wins.
//  - rdata registers hold last captured value until next access by same port.
//  - Reset during ACC: a write whose negedge already passed is committed; no ack issued;
//    next cycle IDLE with mwmem=0; requester must reissue. Reset during RESP: ack dropped.
//  - Address not range-checked; mr[AW-1:8] passes through unchanged.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: tie (both req in IDLE, guard not active) goes to the port not
//    granted last (last_grant register); starvation guard still active.
//  MEM_ARB_RR_EN undefined: tie always goes to C (fixed priority); only the guard lets D in.
// TESTING
//  1 reset held 2 cycles -> all outputs 0, busy=0, mwmem=0 throughout.
//  2 C read addr 0x04 (mem[1]=0x1000_0011) -> c_ack 2 cycles later, c_rdata=0x1000_0011, mwmem=0.
//  3 D write 0x08 <- 0xDEADBEEF, then C read 0x08 -> mwmem=1 only in ACC, c_rdata=0xDEADBEEF.
//  4 c_req,d_req rise together, held -> fixed: C acked then D; RR_EN: C then D, alternating.
//  5 C re-requests every IDLE, d_req held, MAX_WAIT=4, fixed -> exactly 4 c_acks then d_ack.
//  6 reset at posedge during ACC of C write 0x0C <- 0x5 -> no c_ack, mwmem=0 next cycle, mem[3]=0x5.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares the single-port 64-word data memory between the CPU MEM step (port C)
// and a DMA/debug loader (port D). One request is latched per access: the
// memory bus is driven for exactly one cycle (ACC), the read data is captured,
// and the winner gets a one-cycle ack (RESP). An access takes three cycles.
//
// Build option: define MEM_ARB_RR_EN to resolve C/D ties round-robin using
// the last_grant register. Without it, ties always go to C. In both builds
// a starvation guard forces D in after MAX_WAIT consecutive C grants while
// d_req is held.

module data_mem_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mr,
    output logic [DW-1:0] mqb,
    output logic          mwmem,
    input  logic [DW-1:0] mdo,
    output logic          busy
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic       win_d;      // latched winner of the current access: 1 = D
    logic [3:0] wait_cnt;   // consecutive C grants while D was waiting
    logic       any_req;
    logic       guard;
    logic       grant_d;    // winner if a grant is made this cycle: 1 = D
`ifdef MEM_ARB_RR_EN
    logic       last_grant; // port granted most recently: 1 = D
`endif

    assign any_req = c_req | d_req;
    assign guard   = (wait_cnt == WAIT_LIMIT);

    // Pick the winner among the current requests (only used in IDLE).
    always_comb begin
        grant_d = 1'b0;
        if (c_req && d_req) begin
            if (guard) begin
                grant_d = 1'b1;
            end else begin
`ifdef MEM_ARB_RR_EN
                grant_d = ~last_grant;
`else
                grant_d = 1'b0;
`endif
            end
        end else begin
            grant_d = d_req;
        end
    end

    // Access FSM with registered memory bus, acks, read data and starvation counter.
    // The memory bus registers double as the request latch: they are loaded on
    // the way into ACC and cleared on the way out, so mwmem can only be high in ACC.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            win_d    <= 1'b0;
            c_ack    <= 1'b0;
            d_ack    <= 1'b0;
            c_rdata  <= '0;
            d_rdata  <= '0;
            mr       <= '0;
            mqb      <= '0;
            mwmem    <= 1'b0;
            busy     <= 1'b0;
            wait_cnt <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    c_ack <= 1'b0;
                    d_ack <= 1'b0;
                    if (any_req) begin
                        state <= ACC;
                        busy  <= 1'b1;
                        win_d <= grant_d;
                        mr    <= grant_d ? d_addr  : c_addr;
                        mqb   <= grant_d ? d_wdata : c_wdata;
                        mwmem <= grant_d ? d_we    : c_we;
`ifdef MEM_ARB_RR_EN
                        last_grant <= grant_d;
`endif
                    end
                end
                ACC: begin
                    if (win_d) begin
                        d_rdata <= mdo;
                    end else begin
                        c_rdata <= mdo;
                    end
                    mr    <= '0;
                    mqb   <= '0;
                    mwmem <= 1'b0;
                    c_ack <= ~win_d;
                    d_ack <= win_d;
                    state <= RESP;
                end
                RESP: begin
                    c_ack <= 1'b0;
                    d_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    c_ack <= 1'b0;
                    d_ack <= 1'b0;
                    mr    <= '0;
                    mqb   <= '0;
                    mwmem <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // Starvation guard: count C wins while D waits; any D win or idle D clears it.
            if (state == IDLE && any_req) begin
                if (grant_d || !d_req) begin
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
            end else if (!d_req) begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed accesses from C and D against a
// 64-word memory, with a transaction-level model of the arbitration rules
// compared against the DUT outputs every cycle.

module tb_data_mem_arbiter;

    localparam int MAXW = 4;

    logic        clock;
    logic        reset;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_ack, d_ack, mwmem, busy;
    logic [31:0] c_rdata, d_rdata, mr, mqb, mdo;

    int n_chk  = 0;
    int n_pass = 0;

    data_mem_arbiter #(.DW(32), .AW(32), .MAX_WAIT(MAXW)) dut (
        .clock(clock), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mr(mr), .mqb(mqb), .mwmem(mwmem), .mdo(mdo), .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory attached to the DUT: combinational read, write on negedge.
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h1000_0001 + 32'(i * 16);
            ref_mem[i] = 32'h1000_0001 + 32'(i * 16);
        end
    end
    always @(negedge clock) begin
        if (mwmem) mem[mr[7:2]] <= mqb;
    end
    assign mdo = mem[mr[7:2]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an access is a 3-cycle slot (bus cycle, ack cycle, idle cycle).
    int          slot;       // 0 idle, 1 bus cycle, 2 ack cycle
    bit          m_d;        // current winner is D
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_crd, m_drd;
    bit          m_crd_k, m_drd_k;
    int          streak;
    bit          lastd;

    initial begin
        slot = 0; m_d = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        m_crd = 0; m_drd = 0; m_crd_k = 1; m_drd_k = 1; streak = 0; lastd = 1;
        forever begin
            @(posedge clock);
            // a write's negedge inside the bus cycle has already happened
            if (slot == 1 && m_we) ref_mem[m_addr[7:2]] = m_wdata;
            if (reset) begin
                slot = 0; streak = 0; lastd = 1;
                m_crd = 0; m_drd = 0; m_crd_k = 1; m_drd_k = 1;
            end else begin
                if (slot == 0 && (c_req || d_req)) begin
                    if (c_req && d_req) begin
                        if (streak == MAXW) m_d = 1;
                        else begin
`ifdef MEM_ARB_RR_EN
                            m_d = !lastd;
`else
                            m_d = 0;
`endif
                        end
                    end else begin
                        m_d = d_req;
                    end
                    m_we    = m_d ? d_we    : c_we;
                    m_addr  = m_d ? d_addr  : c_addr;
                    m_wdata = m_d ? d_wdata : c_wdata;
                    lastd   = m_d;
                    if (m_d || !d_req) streak = 0; else streak++;
                    slot = 1;
                end else begin
                    if (!d_req) streak = 0;
                    if (slot == 1) begin
                        if (m_d) begin m_drd = ref_mem[m_addr[7:2]]; m_drd_k = !m_we; end
                        else     begin m_crd = ref_mem[m_addr[7:2]]; m_crd_k = !m_we; end
                        slot = 2;
                    end else if (slot == 2) begin
                        slot = 0;
                    end
                end
            end
            #1;
            check("busy",  busy,  (slot != 0));
            check("mwmem", mwmem, (slot == 1) ? m_we : 1'b0);
            check("mr",    mr,    (slot == 1) ? m_addr : 32'h0);
            check("mqb",   mqb,   (slot == 1) ? m_wdata : 32'h0);
            check("c_ack", c_ack, (slot == 2) && !m_d);
            check("d_ack", d_ack, (slot == 2) && m_d);
            if (m_crd_k) check("c_rdata", c_rdata, m_crd);
            if (m_drd_k) check("d_rdata", d_rdata, m_drd);
        end
    end

    int ack_order[$];

    task automatic c_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd);
        bit got = 0;
        rd = 'x;
        c_we = we; c_addr = a; c_wdata = wd; c_req = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clock); #1;
            if (c_ack) begin got = 1; rd = c_rdata; ack_order.push_back(0); end
        end
        #1 c_req = 1'b0;
        if (!got) check("c_timeout", 0, 1);
    endtask

    task automatic d_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd);
        bit got = 0;
        rd = 'x;
        d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clock); #1;
            if (d_ack) begin got = 1; rd = d_rdata; ack_order.push_back(1); end
        end
        #1 d_req = 1'b0;
        if (!got) check("d_timeout", 0, 1);
    endtask

    task automatic do_reset(input int n);
        @(posedge clock); #2 reset = 1'b1;
        repeat (n) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    logic [31:0] rd_c, rd_d;
    bit          d_done;
    int          n_c, late_acks;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        // 1: reset held two cycles
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy",    busy,    0);
        check("rst_mwmem",   mwmem,   0);
        check("rst_c_rdata", c_rdata, 32'h0);
        #1 reset = 1'b0;

        // 2: C read of word 1, also with high address bits set
        c_access(1'b0, 32'h0000_0004, 32'h0, rd_c);
        check("t2_c_rdata", rd_c, 32'h1000_0011);
        c_access(1'b0, 32'hABCD_0104, 32'h0, rd_c);
        check("t2_hi_addr", rd_c, 32'h1000_0011);

        // 3: D write then C and D read back
        d_access(1'b1, 32'h0000_0008, 32'hDEADBEEF, rd_d);
        check("t3_mem", mem[2], 32'hDEADBEEF);
        c_access(1'b0, 32'h0000_0008, 32'h0, rd_c);
        check("t3_c_rdata", rd_c, 32'hDEADBEEF);
        d_access(1'b0, 32'h0000_0008, 32'h0, rd_d);
        check("t3_d_rdata", rd_d, 32'hDEADBEEF);

        // 4: simultaneous requests after a fresh reset
        do_reset(1);
        ack_order.delete();
        fork
            c_access(1'b0, 32'h10, 32'h0, rd_c);
            d_access(1'b0, 32'h14, 32'h0, rd_d);
        join
        check("t4_n_acks", ack_order.size(), 2);
        if (ack_order.size() == 2) begin
            check("t4_first_c",  ack_order[0], 0);
            check("t4_second_d", ack_order[1], 1);
        end
        check("t4_c_rdata", rd_c, 32'h1000_0041);
        check("t4_d_rdata", rd_d, 32'h1000_0051);

        // 5: C keeps re-requesting while D holds its request
        repeat (2) @(posedge clock);
        #2;
        d_done = 0; n_c = 0;
        fork
            begin
                d_access(1'b0, 32'h18, 32'h0, rd_d);
                d_done = 1;
            end
            begin
                while (!d_done) begin
                    c_access(1'b0, 32'h1C, 32'h0, rd_c);
                    if (!d_done) n_c++;
                end
            end
        join
`ifdef MEM_ARB_RR_EN
        check("t5_c_before_d", n_c, 1);
`else
        check("t5_c_before_d", n_c, 4);
`endif
        check("t5_d_rdata", rd_d, 32'h1000_0061);

        // 6: reset lands on the posedge that ends a C write's bus cycle
        repeat (2) @(posedge clock);
        #2;
        c_we = 1'b1; c_addr = 32'h0C; c_wdata = 32'h5; c_req = 1'b1;
        @(posedge clock);
        #1 check("t6_in_acc", mwmem, 1);
        #1 reset = 1'b1; c_req = 1'b0;
        @(posedge clock);
        #1 check("t6_mwmem_after", mwmem, 0);
        #1 reset = 1'b0;
        late_acks = 0;
        repeat (4) begin
            @(posedge clock); #1;
            if (c_ack) late_acks++;
        end
        check("t6_no_ack", late_acks, 0);
        check("t6_mem3", mem[3], 32'h5);

        repeat (2) @(posedge clock);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
